// File: rtl/uart_rx.sv
// uart_rx: UART receiver paired with uart_tx.
// Oversamples the serial line with a 16x baud_tick enable, deframes
// start/data/parity/stop according to the line-control inputs, and
// presents each character in a one-deep holding register.
//
// Ports:
//   sys_clk        system clock, all logic on posedge
//   reset          synchronous active-high reset
//   baud_tick      1-cycle enable, OVERSAMPLE pulses per bit period
//   rxd_i          serial input, idle high, asynchronous to sys_clk
//   parity_en      1 = parity bit present
//   sticky_parity  1 = parity bit forced to ~eps
//   eps            1 = even parity, 0 = odd
//   stop_bit       number of stop bits; only the first one is checked
//   wls            word length = 5 + wls
//   rx_rd_en       consumer pops the holding register
//   rx_data_o      received character, unused MSBs zero
//   rx_valid       holding register full
//   parity_err     parity mismatch for the held character
//   framing_err    first stop bit sampled low
//   break_int      line low for the whole frame including stop
//   overrun_err    character completed while rx_valid was set
//   rx_busy        receiver is inside a frame
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       rxd_i,
  input  logic       parity_en,
  input  logic       sticky_parity,
  input  logic       eps,
  input  logic       stop_bit,
  input  logic [1:0] wls,
  input  logic       rx_rd_en,
  output logic [7:0] rx_data_o,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       break_int,
  output logic       overrun_err,
  output logic       rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_ZERO = TW'(0);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Data is shifted in from the top, so a short word sits in the MSBs.
  function automatic logic [7:0] align_data(input logic [7:0] sh, input logic [1:0] w);
    logic [7:0] d;
    case (w)
      2'b00:   d = {3'b000, sh[7:3]};
      2'b01:   d = {2'b00, sh[7:2]};
      2'b10:   d = {1'b0, sh[7:1]};
      2'b11:   d = sh;
      default: d = sh;
    endcase
    return d;
  endfunction

  // Unused MSBs are zero, so a full 8-bit reduction covers only active bits.
  function automatic logic expected_parity(input logic [7:0] d, input logic sp, input logic ep);
    logic p;
    if (sp) begin
      p = ~ep;
    end else if (ep) begin
      p = ^d;
    end else begin
      p = ~^d;
    end
    return p;
  endfunction

  logic          sync1_r, rxs_r;
  state_t        state_r, state_s;
  logic [TW-1:0] tick_r, tick_s;
  logic [2:0]    bit_r, bit_s;
  logic [7:0]    shift_r, shift_s;
  logic [1:0]    wls_r, wls_s;
  logic          pe_r, pe_s, sp_r, sp_s, ep_r, ep_s;
  logic          par_bit_r, par_bit_s;
  logic          perr_r, perr_s, ferr_r, ferr_s, brk_r, brk_s;
  logic          hold_r, hold_s;
  logic          done_r, done_s;
  logic [7:0]    frame_data_s;
  logic [2:0]    last_bit_s;
  logic          unused_s;

  // Extra stop bits are never checked, so the stop-bit count is not needed.
  assign unused_s     = stop_bit;
  assign frame_data_s = align_data(shift_r, wls_r);
  assign last_bit_s   = 3'd4 + {1'b0, wls_r};

  // Next-state and frame datapath decode
  always_comb begin
    state_s   = state_r;
    tick_s    = tick_r;
    bit_s     = bit_r;
    shift_s   = shift_r;
    wls_s     = wls_r;
    pe_s      = pe_r;
    sp_s      = sp_r;
    ep_s      = ep_r;
    par_bit_s = par_bit_r;
    perr_s    = perr_r;
    ferr_s    = ferr_r;
    brk_s     = brk_r;
    hold_s    = hold_r;
    done_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (hold_r) begin
          // after a break the line must return high before re-arming
          hold_s = ~rxs_r;
        end else if (!rxs_r) begin
          state_s   = S_START;
          tick_s    = TICK_ZERO;
          bit_s     = 3'd0;
          par_bit_s = 1'b0;
          perr_s    = 1'b0;
          wls_s     = wls;
          pe_s      = parity_en;
          sp_s      = sticky_parity;
          ep_s      = eps;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        if (!baud_tick) begin
          state_s = S_START;
        end else if (tick_r != TICK_HALF) begin
          tick_s = tick_r + TICK_ONE;
        end else if (rxs_r) begin
          state_s = S_IDLE;  // start bit did not survive to mid-bit: glitch
        end else begin
          state_s = S_DATA;
          tick_s  = TICK_ZERO;
        end
      end
      S_DATA: begin
        if (!baud_tick) begin
          state_s = S_DATA;
        end else if (tick_r != TICK_LAST) begin
          tick_s = tick_r + TICK_ONE;
        end else begin
          tick_s  = TICK_ZERO;
          shift_s = {rxs_r, shift_r[7:1]};
          if (bit_r == last_bit_s) begin
            bit_s   = 3'd0;
            state_s = pe_r ? S_PARITY : S_STOP;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (!baud_tick) begin
          state_s = S_PARITY;
        end else if (tick_r != TICK_LAST) begin
          tick_s = tick_r + TICK_ONE;
        end else begin
          tick_s    = TICK_ZERO;
          par_bit_s = rxs_r;
          perr_s    = (rxs_r != expected_parity(frame_data_s, sp_r, ep_r));
          state_s   = S_STOP;
        end
      end
      S_STOP: begin
        if (!baud_tick) begin
          state_s = S_STOP;
        end else if (tick_r != TICK_LAST) begin
          tick_s = tick_r + TICK_ONE;
        end else begin
          tick_s  = TICK_ZERO;
          state_s = S_IDLE;
          done_s  = 1'b1;
          ferr_s  = ~rxs_r;
          brk_s   = ~rxs_r & (frame_data_s == 8'h00) & (~pe_r | ~par_bit_r);
          hold_s  = ~rxs_r & (frame_data_s == 8'h00) & (~pe_r | ~par_bit_r);
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Line synchronizer, FSM state and frame datapath registers
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sync1_r   <= 1'b1;
      rxs_r     <= 1'b1;
      state_r   <= S_IDLE;
      tick_r    <= TICK_ZERO;
      bit_r     <= 3'd0;
      shift_r   <= 8'h00;
      wls_r     <= 2'b00;
      pe_r      <= 1'b0;
      sp_r      <= 1'b0;
      ep_r      <= 1'b0;
      par_bit_r <= 1'b0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      brk_r     <= 1'b0;
      hold_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      sync1_r   <= rxd_i;
      rxs_r     <= sync1_r;
      state_r   <= state_s;
      tick_r    <= tick_s;
      bit_r     <= bit_s;
      shift_r   <= shift_s;
      wls_r     <= wls_s;
      pe_r      <= pe_s;
      sp_r      <= sp_s;
      ep_r      <= ep_s;
      par_bit_r <= par_bit_s;
      perr_r    <= perr_s;
      ferr_r    <= ferr_s;
      brk_r     <= brk_s;
      hold_r    <= hold_s;
      done_r    <= done_s;
    end
  end

  // Holding register, status flags and read handshake
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rx_data_o   <= 8'h00;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      break_int   <= 1'b0;
      overrun_err <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      rx_busy <= (state_s != S_IDLE);
      if (done_r) begin
        rx_data_o   <= frame_data_s;
        parity_err  <= perr_r;
        framing_err <= ferr_r;
        break_int   <= brk_r;
        rx_valid    <= 1'b1;
        if (rx_valid && !rx_rd_en) begin
          overrun_err <= 1'b1;
        end else if (rx_valid && rx_rd_en) begin
          overrun_err <= 1'b0;  // same-cycle pop frees the slot
        end else begin
          overrun_err <= overrun_err;
        end
      end else if (rx_rd_en && rx_valid) begin
        rx_valid    <= 1'b0;
        parity_err  <= 1'b0;
        framing_err <= 1'b0;
        break_int   <= 1'b0;
        overrun_err <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. A behavioural transmitter
// builds frames bit by bit from the line-control rules, and a small model
// of the holding register predicts data, flags and overrun.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int OS  = 16;
  localparam int DIV = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rxd = 1'b1;
  logic       parity_en = 1'b0;
  logic       sticky_parity = 1'b0;
  logic       eps = 1'b0;
  logic       stop_bit = 1'b0;
  logic [1:0] wls = 2'b00;
  logic       rx_rd_en = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid, parity_err, framing_err, break_int, overrun_err, rx_busy;

  int errors = 0;
  int checks = 0;

  // reference model of the holding register
  logic       m_valid = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_brk = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_data = 8'h00;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .sys_clk      (clk),
    .reset        (reset),
    .baud_tick    (baud_tick),
    .rxd_i        (rxd),
    .parity_en    (parity_en),
    .sticky_parity(sticky_parity),
    .eps          (eps),
    .stop_bit     (stop_bit),
    .wls          (wls),
    .rx_rd_en     (rx_rd_en),
    .rx_data_o    (rx_data_o),
    .rx_valid     (rx_valid),
    .parity_err   (parity_err),
    .framing_err  (framing_err),
    .break_int    (break_int),
    .overrun_err  (overrun_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  // baud tick: one sys_clk pulse every DIV cycles, driven on the falling edge
  initial begin : tick_gen
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      baud_tick = (cnt == DIV - 1);
      cnt = (cnt == DIV - 1) ? 0 : cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "/valid"}, {7'd0, rx_valid}, {7'd0, m_valid});
    check({tag, "/data"}, rx_data_o, m_data);
    check({tag, "/perr"}, {7'd0, parity_err}, {7'd0, m_perr});
    check({tag, "/ferr"}, {7'd0, framing_err}, {7'd0, m_ferr});
    check({tag, "/brk"}, {7'd0, break_int}, {7'd0, m_brk});
    check({tag, "/ovr"}, {7'd0, overrun_err}, {7'd0, m_ovr});
    check({tag, "/busy"}, {7'd0, rx_busy}, 8'd0);
  endtask

  // wait for n baud ticks, then step just past the edge
  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (baud_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic model_complete(input logic [7:0] d, input logic pe, input logic ferr, input logic brk);
    if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1;
    m_data  = d;
    m_perr  = pe;
    m_ferr  = ferr;
    m_brk   = brk;
  endtask

  task automatic model_clear();
    m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_brk = 1'b0; m_ovr = 1'b0; m_data = 8'h00;
  endtask

  task automatic pop(input string tag);
    @(negedge clk) rx_rd_en = 1'b1;
    @(negedge clk) rx_rd_en = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_brk = 1'b0; m_ovr = 1'b0;
    end
    check_outputs(tag);
  endtask

  // transmit one frame; a low stop bit is held past mid-bit then released
  task automatic send_frame(input logic [7:0] data, input logic [1:0] w, input logic pe,
                            input logic sp, input logic ep, input logic sb,
                            input logic flip_par, input logic stop_val, input int gap);
    int         n;
    int         ones;
    logic [7:0] all_ones;
    logic [7:0] d;
    logic       pbit;
    logic       sent_p;
    n        = 5 + int'(w);
    all_ones = 8'hFF;
    d        = data & (all_ones >> (3 - int'(w)));
    ones     = $countones(d);
    if (sp) pbit = ~ep;
    else if (ep) pbit = (ones % 2 == 1);
    else pbit = (ones % 2 == 0);
    sent_p = pbit ^ flip_par;
    wls = w; parity_en = pe; sticky_parity = sp; eps = ep; stop_bit = sb;
    rxd = 1'b0;
    wait_ticks(OS);
    // the receiver must ignore line-control changes inside a frame
    {wls, parity_en, sticky_parity, eps, stop_bit} = 6'($urandom);
    for (int i = 0; i < n; i++) begin
      rxd = d[i];
      wait_ticks(OS);
    end
    if (pe) begin
      rxd = sent_p;
      wait_ticks(OS);
    end
    rxd = stop_val;
    wait_ticks(10);
    rxd = 1'b1;
    wait_ticks(OS - 10 + gap);
    model_complete(d, pe && (sent_p != pbit), !stop_val,
                   (d == 8'h00) && (!pe || !sent_p) && !stop_val);
  endtask

  initial begin : main
    logic [7:0] rd;
    logic [1:0] rw;
    logic       rpe, rsp, rep, rsb, rflip, rstop;

    repeat (4) @(posedge clk);
    #1;
    model_clear();
    check_outputs("reset");
    @(negedge clk) reset = 1'b0;
    wait_ticks(4);

    send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8);
    check_outputs("8N1_A5");
    pop("pop_A5");

    send_frame(8'h5A, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8);
    check_outputs("7E1_5A");
    pop("pop_5A");
    send_frame(8'h5A, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8);
    check_outputs("7E1_bad_par");
    pop("pop_bad_par");

    send_frame(8'h3C, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8);
    check_outputs("6O1_3C");
    pop("pop_3C");
    send_frame(8'h00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8);
    check_outputs("sticky_00");
    pop("pop_00");

    send_frame(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8);
    check_outputs("framing_C3");
    pop("pop_C3");

    // break: line low for 12 bit times on an 8N1 configuration
    wls = 2'b11; parity_en = 1'b0; sticky_parity = 1'b0; eps = 1'b0; stop_bit = 1'b0;
    rxd = 1'b0;
    wait_ticks(12 * OS);
    rxd = 1'b1;
    wait_ticks(OS);
    model_complete(8'h00, 1'b0, 1'b1, 1'b1);
    check_outputs("break");
    pop("pop_break");

    // single-tick low pulse on the idle line
    rxd = 1'b0;
    wait_ticks(1);
    rxd = 1'b1;
    wait_ticks(OS + 4);
    check_outputs("glitch");

    // two frames without a read
    send_frame(8'h11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8);
    send_frame(8'h22, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8);
    check_outputs("overrun");
    pop("pop_overrun");

    // reset in the middle of the data bits, with a character still held
    send_frame(8'h77, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8);
    check_outputs("pre_reset");
    wls = 2'b11; parity_en = 1'b0;
    rxd = 1'b0;
    wait_ticks(OS);
    rxd = 1'b1;
    wait_ticks(40);
    check("mid_data_busy", {7'd0, rx_busy}, 8'd1);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    model_clear();
    check_outputs("mid_reset");
    reset = 1'b0;
    wait_ticks(2 * OS);
    send_frame(8'h1F, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8);
    check_outputs("5N15_1F");
    pop("pop_1F");

    // randomized frames with random configuration, corruption and reads
    for (int k = 0; k < 24; k++) begin
      rd    = 8'($urandom);
      if ($urandom_range(0, 9) == 0) rd = 8'h00;
      rw    = 2'($urandom);
      rpe   = 1'($urandom);
      rsp   = ($urandom_range(0, 3) == 0);
      rep   = 1'($urandom);
      rsb   = 1'($urandom);
      rflip = rpe && ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 4) != 0);
      send_frame(rd, rw, rpe, rsp, rep, rsb, rflip, rstop, $urandom_range(4, 20));
      check_outputs($sformatf("rand%0d", k));
      if ($urandom_range(0, 9) < 6) pop($sformatf("rand_pop%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
